// File: rtl/switch_adder_pkg.sv
// Shared constants for the switch adder / accumulator board block.
package switch_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchroniser, then a counter-qualified FSM
// that emits one pulse per accepted press. level_in is active-high (pressed=1).
//
//   state        | meaning
//   RELEASED     | button accepted as released
//   PRESS_WAIT   | pressed level seen, counting stable samples
//   PRESSED      | button accepted as pressed (pulse already emitted)
//   RELEASE_WAIT | released level seen, counting stable samples
module button_debouncer
    import switch_adder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level_in,
    output logic       pulse_out,
    output deb_state_t state_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= level_in;
            r_sync2 <= r_sync1;
        end
    end

    // The sample that enters a WAIT state counts as the first stable one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (r_sync2) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync2) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pulse_out = r_pulse;
    assign state_out = r_state;

endmodule

// File: rtl/switch_adder_acc.sv
// Board top: switch adder (ADD mode) and button-driven wrapping accumulator
// with sticky overflow (ACC mode), shown on registered LEDs.
module switch_adder_acc
    import switch_adder_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_a,
    input  logic [WIDTH-1:0] switch_b,
    input  logic             switch_cin,
    input  logic             switch_mode,
    input  logic             button_add_n,
    input  logic             button_clr_n,
    output logic [WIDTH-1:0] led_sum,
    output logic             led_carry,
    output logic             led_mode
);

    logic [WIDTH-1:0] r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic             r_cin_s1, r_cin_s2, r_mode_s1, r_mode_s2;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [WIDTH-1:0] r_led_sum;
    logic             r_led_carry;
    logic             r_led_mode;

    logic             w_add_pulse;
    logic             w_clr_pulse;
    deb_state_t       w_unused_add_state;
    deb_state_t       w_unused_clr_state;
    logic [WIDTH:0]   w_add_full;
    logic [WIDTH:0]   w_acc_full;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_ovf_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_s1    <= '0;
            r_a_s2    <= '0;
            r_b_s1    <= '0;
            r_b_s2    <= '0;
            r_cin_s1  <= 1'b0;
            r_cin_s2  <= 1'b0;
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
        end else begin
            r_a_s1    <= switch_a;
            r_a_s2    <= r_a_s1;
            r_b_s1    <= switch_b;
            r_b_s2    <= r_b_s1;
            r_cin_s1  <= switch_cin;
            r_cin_s2  <= r_cin_s1;
            r_mode_s1 <= switch_mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_add (
        .clk      (clk),
        .rst_n    (rst_n),
        .level_in (~button_add_n),
        .pulse_out(w_add_pulse),
        .state_out(w_unused_add_state)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .level_in (~button_clr_n),
        .pulse_out(w_clr_pulse),
        .state_out(w_unused_clr_state)
    );

    assign w_add_full = {1'b0, r_a_s2} + {1'b0, r_b_s2} + (WIDTH+1)'(r_cin_s2);
    assign w_acc_full = {1'b0, r_acc} + {1'b0, r_a_s2} + (WIDTH+1)'(r_cin_s2);

    // Mode decisions use the value being loaded into led_mode this edge, so a
    // pulse coinciding with a mode change is handled under the new mode.
    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf;
        if (w_clr_pulse) begin
            w_acc_next = '0;
            w_ovf_next = 1'b0;
        end else if (w_add_pulse && (r_mode_s2 == MODE_ACC)) begin
            w_acc_next = w_acc_full[WIDTH-1:0];
            w_ovf_next = r_ovf | w_acc_full[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_led_sum   <= '0;
            r_led_carry <= 1'b0;
            r_led_mode  <= 1'b0;
        end else begin
            r_acc      <= w_acc_next;
            r_ovf      <= w_ovf_next;
            r_led_mode <= r_mode_s2;
            if (r_mode_s2 == MODE_ADD) begin
                r_led_sum   <= w_add_full[WIDTH-1:0];
                r_led_carry <= w_add_full[WIDTH];
            end else begin
                r_led_sum   <= w_acc_next;
                r_led_carry <= w_ovf_next;
            end
        end
    end

    assign led_sum   = r_led_sum;
    assign led_carry = r_led_carry;
    assign led_mode  = r_led_mode;

endmodule
